// File: rtl/h264_sync_fifo_pkg.sv
// Shared constants and types for the codec stage FIFOs.
// Defaults match the common pixel/coefficient stage configuration.
package h264_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_PTR_WIDTH  = clog2(FIFO_DEPTH);
  localparam int FIFO_AF_THRESH  = 12;
  localparam int FIFO_AE_THRESH  = 2;

  // Fill level spans 0..DEPTH inclusive, hence one extra bit.
  typedef logic [FIFO_PTR_WIDTH:0] fifo_level_t;

endpackage

// File: rtl/h264_sync_fifo_if.sv
// Write/read handshake bundle of the stage FIFO.
// valid/ready: a word moves on a rising edge where both are high; valid never waits on ready.
interface h264_sync_fifo_if import h264_fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) ();
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;

  modport slave (
    input  wr_valid_i, wr_data_i, rd_ready_i,
    output wr_ready_o, rd_valid_o, rd_data_o
  );

  modport master (
    output wr_valid_i, wr_data_i, rd_ready_i,
    input  wr_ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/h264_sync_fifo_ram.sv
// Storage array: one synchronous write port, combinational read port.
// The array carries no reset; control logic never reads an unwritten slot.
module h264_sync_fifo_ram import h264_fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int PTR_WIDTH  = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/h264_sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head register,
// fill level, almost flags, synchronous flush and sticky error flags.
module h264_sync_fifo import h264_fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int PTR_WIDTH  = clog2(DEPTH),
  parameter int AF_THRESH  = FIFO_AF_THRESH,
  parameter int AE_THRESH  = FIFO_AE_THRESH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  h264_sync_fifo_if.slave      bus,
  output logic [PTR_WIDTH:0]   level_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);
  localparam logic [PTR_WIDTH:0] ONE       = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] DEPTH_LVL = DEPTH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AF_LVL    = AF_THRESH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE_LVL    = AE_THRESH[PTR_WIDTH:0];

  logic [PTR_WIDTH:0]    wptr, rptr;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic ram_empty, full, wr_acc, rd_acc, out_free, load_ram, bypass, ram_we;

  assign ram_empty = (wptr == rptr);
  assign full      = (level_o == DEPTH_LVL);
  assign wr_acc    = bus.wr_valid_i & !full;
  assign rd_acc    = rd_valid_q & bus.rd_ready_i;
  // Head register can take a new word if it is empty or being drained now.
  assign out_free  = !rd_valid_q | bus.rd_ready_i;
  assign load_ram  = out_free & !ram_empty;
  assign bypass    = out_free & ram_empty & wr_acc;
  assign ram_we    = wr_acc & !bypass & !flush_i;

  h264_sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wptr[PTR_WIDTH-1:0]),
    .wdata(bus.wr_data_i),
    .raddr(rptr[PTR_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      level_o     <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      wptr        <= '0;
      rptr        <= '0;
      level_o     <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (ram_we) wptr <= wptr + ONE;
      if (load_ram) begin
        rd_data_q  <= ram_rdata;
        rd_valid_q <= 1'b1;
        rptr       <= rptr + ONE;
      end else if (bypass) begin
        rd_data_q  <= bus.wr_data_i;
        rd_valid_q <= 1'b1;
      end else if (rd_acc) begin
        rd_valid_q <= 1'b0;
      end
      // Simultaneous accept leaves the level unchanged.
      if (wr_acc && !rd_acc)      level_o <= level_o + ONE;
      else if (!wr_acc && rd_acc) level_o <= level_o - ONE;
      if (bus.wr_valid_i && full)          overflow_o  <= 1'b1;
      if (bus.rd_ready_i && !rd_valid_q)   underflow_o <= 1'b1;
    end
  end

  assign bus.wr_ready_o = !full;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign almost_full_o  = (level_o >= AF_LVL);
  assign almost_empty_o = (level_o <= AE_LVL);
endmodule

// File: doc/h264_sync_fifo.md
Name: h264_sync_fifo

Overview:
Single-clock, parametrised FIFO for the H.264 codec IP. It buffers pixel and coefficient words between pipeline stages, such as intra-prediction to transform, or entropy coder to bus master. Storage is a flop/LUT array with combinational read. A registered first-word-fall-through output stage drives a valid/ready interface. The block also provides a fill level, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 8, width of one data word
DEPTH, 16, total capacity in words (output register included); power of two, at least 4
PTR_WIDTH, 4, log2(DEPTH); RAM address width, pointers are PTR_WIDTH+1 bits
AF_THRESH, 12, almost_full_o asserted when level_o >= AF_THRESH
AE_THRESH, 2, almost_empty_o asserted when level_o <= AE_THRESH

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of contents and error flags
wr_valid_i  in  1  write request
wr_ready_o  out  1  space available (= !full)
wr_data_i  in  DATA_WIDTH  write data
rd_valid_o  out  1  output register holds a word
rd_ready_i  in  1  consumer accepts the word
rd_data_o  out  DATA_WIDTH  head-of-queue data, registered
level_o  out  PTR_WIDTH+1  words held, range 0..DEPTH
almost_full_o  out  1  level_o >= AF_THRESH
almost_empty_o  out  1  level_o <= AE_THRESH
overflow_o  out  1  sticky: write attempted while full
underflow_o  out  1  sticky: rd_ready_i high while rd_valid_o low

Behaviour:
- Reset (async assert, sync release): pointers=0, level_o=0, rd_valid_o=0, rd_data_o=0, wr_ready_o=1, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0. Reset mid-transfer discards all contents.
- Write accept = wr_valid_i & wr_ready_o. Read accept = rd_valid_o & rd_ready_i.
- The output register is part of capacity. RAM holds at most DEPTH-1 words while the output register is valid.
- Output register load, each cycle, in priority order:
  - (a) If it is empty or being consumed and the RAM is non-empty, load RAM[rptr] and advance rptr.
  - (b) Else, if it is empty or being consumed and the RAM is empty and a write is accepted, load wr_data_i directly (bypass). The RAM is not written.
  - (c) Else, if it is being consumed, clear rd_valid_o.
- Any accepted write that is not bypassed goes to RAM[wptr], and wptr advances.
- Latency: a write accepted at edge N into an empty FIFO gives rd_valid_o=1 and rd_data_o valid after edge N; the consumer sees it in cycle N+1.
- Full/empty: full when level_o==DEPTH; RAM empty when wptr==rptr; RAM full when MSBs differ and LSBs are equal. Pointers wrap naturally modulo 2*DEPTH.
- level_o is registered: +1 on write-only, -1 on read-only, unchanged on simultaneous accept. Simultaneous write and read are both accepted even when full is reached in that cycle (the read frees no space until the next cycle; wr_ready_o is registered-full based).
- Flags:
  - Almost flags are combinational from level_o.
  - overflow_o sets on wr_valid_i & !wr_ready_o; the write is dropped and state is unchanged.
  - underflow_o sets on rd_ready_i & !rd_valid_o.
  - Both flags hold until flush_i or reset.
- flush_i has priority over same-cycle writes and reads. On flush, the next state equals the reset state; the write is discarded and no error flag is set that cycle.
- rd_data_o holds its last value when rd_valid_o=0 and is never X after reset.

Decomposition:
- Package h264_fifo_pkg:
  - localparam helper function clog2
  - default width/depth constants for codec stage FIFOs
  - typedef for the level count
- One sub-module: h264_sync_fifo_ram. It is the storage array with a single write port (clk, we, waddr, wdata) and a combinational read port (raddr, rdata), and has no reset on the array.
- Control, bypass, the output register and flags live in the top.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> level_o=0, rd_valid_o=0, wr_ready_o=1, almost_empty_o=1, all error flags 0.
- Bypass latency: write 0xA5 into an empty FIFO at cycle 0 with rd_ready_i=0 -> rd_valid_o=1 and rd_data_o=0xA5 at cycle 1, level_o=1.
- Fill and overflow: write 16 words 0x00..0x0F with rd_ready_i=0 -> wr_ready_o=0 and level_o=16 after the 16th write, almost_full_o from level 12. A 17th write attempt sets overflow_o=1 and data is unchanged. Then drain with rd_ready_i=1 -> 0x00..0x0F in order with no gaps, and level_o returns to 0.
- Streaming at full rate: wr_valid_i=1 and rd_ready_i=1 for 100 cycles with an incrementing pattern -> one word per cycle in order, level_o steady at 1, no flags set.
- Pointer wrap with random back-pressure: 1000 words, random wr_valid_i and rd_ready_i (50%) -> scoreboard match, level_o always equals the model, and it never exceeds 16.
- Flush and async reset mid-operation: with level 7, assert flush_i together with wr_valid_i -> next cycle level_o=0, rd_valid_o=0, flags cleared. Assert rst_n low mid-burst -> outputs reach their reset values immediately, without waiting for a clock edge.
